// File: rtl/core_if_checker.sv
// rtl/core_if_checker.sv - passive req/gnt/rvalid bus protocol checker
// Optional X/Z detection on bits 0/1 is enabled by defining CORE_CHK_X_EN.
module core_if_checker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RVALID_TIMEOUT  = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req,
    input  logic [ADDR_WIDTH-1:0]                  addr,
    input  logic                                   we,
    input  logic [BE_WIDTH-1:0]                    be,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    input  logic                                   gnt,
    input  logic                                   rvalid,
    input  logic [DATA_WIDTH-1:0]                  rdata,
    input  logic                                   clr,
    output logic [7:0]                             err_vec,
    output logic                                   err_pulse,
    output logic [2:0]                             first_err_code,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [31:0]                            rd_cnt,
    output logic [31:0]                            wr_cnt
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(RVALID_TIMEOUT + 1);

    logic                  pending;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_we;
    logic [BE_WIDTH-1:0]   cap_be;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [TW-1:0]         tmo_cnt;
    logic [7:0]            new_err;
    logic [2:0]            new_code;
    logic                  grant;
    logic                  ovf;
    logic [OW-1:0]         out_nxt;

    always_comb begin
        grant      = req & gnt;
        ovf        = grant & (outstanding == OW'(MAX_OUTSTANDING)) & ~rvalid;
        new_err    = '0;
        new_err[2] = pending & req & ((addr != cap_addr) | (we != cap_we) | (be != cap_be) |
                                      (cap_we & (wdata != cap_wdata)));
        new_err[3] = pending & ~req;
        new_err[4] = rvalid & (outstanding == '0);
        new_err[5] = ovf;
        new_err[6] = (outstanding != '0) & ~rvalid & (tmo_cnt == TW'(RVALID_TIMEOUT - 1));
`ifdef CORE_CHK_X_EN
        new_err[0] = ((^req) === 1'bx) ||
                     ((req === 1'b1) && (((^{addr, we, be}) === 1'bx) ||
                                         ((we === 1'b1) && ((^wdata) === 1'bx))));
        new_err[1] = (rvalid === 1'b1) && ((^rdata) === 1'bx);
`endif
        out_nxt = outstanding;
        if (grant && !ovf)
            out_nxt = out_nxt + OW'(1);
        if (rvalid && (outstanding != '0))
            out_nxt = out_nxt - OW'(1);
        new_code = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (new_err[i])
                new_code = 3'(i);
    end

`ifndef CORE_CHK_X_EN
    logic unused_rdata;
    assign unused_rdata = ^rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending        <= 1'b0;
            cap_addr       <= '0;
            cap_we         <= 1'b0;
            cap_be         <= '0;
            cap_wdata      <= '0;
            outstanding    <= '0;
            tmo_cnt        <= '0;
            err_vec        <= '0;
            err_pulse      <= 1'b0;
            first_err_code <= '0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
        end else begin
            pending     <= req & ~gnt;
            cap_addr    <= addr;
            cap_we      <= we;
            cap_be      <= be;
            cap_wdata   <= wdata;
            outstanding <= out_nxt;
            // Saturates at the limit so the timeout reports only once per stall
            if ((outstanding == '0) || rvalid)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(RVALID_TIMEOUT))
                tmo_cnt <= tmo_cnt + TW'(1);
            err_pulse <= |new_err;
            if (clr) begin
                err_vec        <= new_err;
                first_err_code <= (|new_err) ? new_code : 3'd0;
                rd_cnt         <= '0;
                wr_cnt         <= '0;
            end else begin
                err_vec <= err_vec | new_err;
                if ((err_vec == '0) && (|new_err))
                    first_err_code <= new_code;
                if (grant && !we)
                    rd_cnt <= rd_cnt + 32'd1;
                if (grant && we)
                    wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_core_if_checker.sv
// tb/tb_core_if_checker.sv - randomized self-checking bench for core_if_checker
module tb_core_if_checker;
    localparam int MAXO = 2;
    localparam int TMO  = 8;

    logic        clk = 0;
    logic        rst, req, we, gnt, rvalid, clr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [7:0]  err_vec;
    logic        err_pulse;
    logic [2:0]  first_err_code;
    logic [1:0]  outstanding;
    logic [31:0] rd_cnt, wr_cnt;

    int n_chk = 0;
    int n_fail = 0;

    core_if_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
                      .MAX_OUTSTANDING(MAXO), .RVALID_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .clr(clr), .err_vec(err_vec),
        .err_pulse(err_pulse), .first_err_code(first_err_code), .outstanding(outstanding),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the bus
    int          m_out, m_wait;
    logic [7:0]  m_vec, m_new;
    logic        m_pulse;
    logic [2:0]  m_first;
    logic [31:0] m_rd, m_wr;
    logic        p_pend, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    int          m_next;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_out = 0; m_wait = 0; m_vec = 0; m_pulse = 0; m_first = 0; m_rd = 0; m_wr = 0;
            p_pend = 0; p_we = 0; p_addr = 0; p_wdata = 0; p_be = 0;
        end else begin
            m_new = 0;
            if (p_pend && req && (addr != p_addr || we != p_we || be != p_be ||
                                  (p_we && wdata != p_wdata))) m_new[2] = 1;
            if (p_pend && !req) m_new[3] = 1;
            if (rvalid && m_out == 0) m_new[4] = 1;
            if (req && gnt && m_out == MAXO && !rvalid) m_new[5] = 1;
            if (m_out == 0 || rvalid) m_wait = 0;
            else begin
                m_wait++;
                if (m_wait == TMO) m_new[6] = 1;
            end
            m_next = m_out;
            if (req && gnt && !m_new[5]) m_next++;
            if (rvalid && m_out > 0) m_next--;
            m_out = m_next;
            m_pulse = (m_new != 0);
            if (clr) begin
                m_vec = m_new;
                m_first = (m_new != 0) ? lowest(m_new) : 3'd0;
                m_rd = 0; m_wr = 0;
            end else begin
                if (m_vec == 0 && m_new != 0) m_first = lowest(m_new);
                m_vec = m_vec | m_new;
                if (req && gnt && !we) m_rd++;
                if (req && gnt && we) m_wr++;
            end
            p_pend = req && !gnt; p_addr = addr; p_we = we; p_be = be; p_wdata = wdata;
        end
        #1;
        chk("err_vec", 32'(err_vec), 32'(m_vec));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("first_err_code", 32'(first_err_code), 32'(m_first));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("rd_cnt", rd_cnt, m_rd);
        chk("wr_cnt", wr_cnt, m_wr);
    end

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic g,
                        input logic rv, input logic c);
        req = r; addr = a; we = w; gnt = g; rvalid = rv; clr = c;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    int pulses;
    logic hold;

    initial begin
        rst = 1; req = 0; addr = 0; we = 0; be = 4'hf; wdata = 0; gnt = 0; rvalid = 0;
        rdata = 0; clr = 0;
        @(negedge clk); @(negedge clk);
        chk("reset err_vec", 32'(err_vec), 0);
        chk("reset rd_cnt", rd_cnt, 0);
        rst = 0;

        repeat (3) step(1, 32'h100, 0, 0, 0, 0);
        step(1, 32'h100, 0, 1, 0, 0);
        chk("read outstanding", 32'(outstanding), 1);
        chk("read rd_cnt", rd_cnt, 1);
        idle();
        step(0, 0, 0, 0, 1, 0);
        chk("read drained", 32'(outstanding), 0);
        chk("read no err", 32'(err_vec), 0);

        step(1, 32'h100, 0, 0, 0, 0);
        step(1, 32'h104, 0, 0, 0, 0);
        chk("unstable vec", 32'(err_vec), 32'h04);
        chk("unstable pulse", 32'(err_pulse), 1);
        chk("unstable code", 32'(first_err_code), 2);
        step(1, 32'h104, 0, 1, 0, 0);
        chk("unstable pulse gone", 32'(err_pulse), 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);

        repeat (3) step(1, 32'h200, 0, 1, 0, 0);
        chk("overflow vec", 32'(err_vec), 32'h20);
        chk("overflow hold", 32'(outstanding), 2);
        chk("overflow code", 32'(first_err_code), 5);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);

        step(0, 0, 0, 0, 1, 0);
        chk("early vec", 32'(err_vec), 32'h10);
        chk("early outstanding", 32'(outstanding), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("clr vec", 32'(err_vec), 0);
        chk("clr code", 32'(first_err_code), 0);

        step(1, 32'h300, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            idle();
            pulses += int'(err_pulse);
            if (i == 7) chk("timeout not yet", 32'(err_vec[6]), 0);
            if (i == 8) chk("timeout set", 32'(err_vec), 32'h40);
        end
        chk("timeout single pulse", pulses, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);

        wdata = 32'h1234_0000;
        step(1, 32'h400, 1, 1, 0, 0);
        chk("write wr_cnt", wr_cnt, 1);
        chk("write no err", 32'(err_vec), 0);
        step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            hold = req && !gnt && ($urandom_range(0, 9) != 0);
            if (!hold) begin
                req = $urandom_range(0, 1);
                addr = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
                we = $urandom_range(0, 1);
                be = 4'($urandom_range(0, 15));
                wdata = $urandom;
            end
            gnt = $urandom_range(0, 2) == 0;
            rvalid = (i % 1000 < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            rdata = $urandom;
            clr = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 299) == 0;
            @(negedge clk);
        end
        rst = 0;
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
